// File: rtl/zint_arb_if.sv
// Bus bundle between the ports block, the ZX INT arbiter and the open-drain zint_n driver.
// The arbiter uses the slave modport; whatever drives requests, enables and acks uses master.
interface zint_arb_if;
    logic       w5300_int_n;
    logic       sl811_intrq;
    logic       ena_w5300_int;
    logic       ena_sl811_int;
    logic       ena_zxbus_int;
    logic       ack_stb;
    logic [1:0] ack_mask;
    logic [1:0] pending;
    logic [1:0] src;
    logic       int_active;
    logic       internal_int;

    modport master (
        output w5300_int_n, sl811_intrq,
        output ena_w5300_int, ena_sl811_int, ena_zxbus_int,
        output ack_stb, ack_mask,
        input  pending, src, int_active, internal_int
    );

    modport slave (
        input  w5300_int_n, sl811_intrq,
        input  ena_w5300_int, ena_sl811_int, ena_zxbus_int,
        input  ack_stb, ack_mask,
        output pending, src, int_active, internal_int
    );
endinterface

// File: rtl/zint_arb.sv
// zint_arb: shares the single ZX-bus INT line between the W5300 and SL811 interrupts.
// Requests are synchronised and edge-detected into pending bits; a round-robin FSM
// drives a fixed-width INT pulse followed by a mandatory re-arm gap.
module zint_arb #(
    parameter int PULSE_CYC = 32,
    parameter int GAP_CYC   = 256,
    parameter int CNT_W     = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    zint_arb_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] C_GAP_LOAD   = CNT_W'(GAP_CYC - 1);

    logic [1:0]       w_req;
    logic [1:0]       w_ena;
    logic [1:0]       w_rise;
    logic [1:0]       w_ack_clr;
    logic [1:0]       w_pending_nxt;
    logic             w_settled;
    logic             w_grant;

    logic [1:0]       r_sync1;
    logic [1:0]       r_sync2;
    logic [1:0]       r_hist;
    logic [1:0]       r_settle;
    logic [1:0]       r_pending;
    logic [1:0]       r_src;
    logic             r_last;
    logic             r_int_active;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;

    // Bit 0 is the W5300, bit 1 the SL811; both normalised to active-high.
    assign w_req = {bus.sl811_intrq, ~bus.w5300_int_n};
    assign w_ena = {bus.ena_sl811_int, bus.ena_w5300_int};

    // After reset the synchroniser and history flops start at 0, so a request held
    // through reset would look like a rising edge once it reaches sync2. Edges are
    // ignored until hist has caught up with sync2 (three clocks after reset).
    assign w_settled = (r_settle == 2'd3);
    assign w_rise    = r_sync2 & ~r_hist & {2{w_settled}};

    // Disable clears a bit unconditionally; otherwise a new edge beats a coincident ack.
    assign w_ack_clr     = {2{bus.ack_stb}} & bus.ack_mask;
    assign w_pending_nxt = w_ena & (w_rise | (r_pending & ~w_ack_clr));

    // On a tie serve the source that did not get the previous pulse.
    assign w_grant = (r_pending == 2'b11) ? ~r_last : r_pending[1];

    // Two-flop synchroniser, history flop and the post-reset settle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1  <= 2'b00;
            r_sync2  <= 2'b00;
            r_hist   <= 2'b00;
            r_settle <= 2'd0;
        end else begin
            r_sync1 <= w_req;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            if (!w_settled) begin
                r_settle <= r_settle + 2'd1;
            end
        end
    end

    // Pending request latches, set by a request edge and cleared by ack or disable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= 2'b00;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Pulse/gap FSM with round-robin grant; INT and src are registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_last       <= 1'b1;
            r_src        <= 2'b00;
            r_int_active <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.ena_zxbus_int && (|r_pending)) begin
                        r_cnt        <= C_PULSE_LOAD;
                        r_src        <= w_grant ? 2'b10 : 2'b01;
                        r_last       <= w_grant;
                        r_int_active <= 1'b1;
                        r_state      <= PULSE;
                    end
                end
                PULSE: begin
                    if (!bus.ena_zxbus_int || (r_cnt == '0)) begin
                        r_cnt        <= C_GAP_LOAD;
                        r_int_active <= 1'b0;
                        r_state      <= GAP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_int_active <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pending      = r_pending;
    assign bus.src          = r_src;
    assign bus.int_active   = r_int_active;
    assign bus.internal_int = |r_pending;

endmodule

// File: tb/tb_zint_arb.sv
// Directed testbench for zint_arb: expected INT pulses (source, start cycle, width)
// are queued as stimulus is applied and matched by a pulse monitor.
module tb_zint_arb;

    localparam int PULSE_CYC = 32;
    localparam int GAP_CYC   = 256;
    localparam int PERIOD    = PULSE_CYC + GAP_CYC + 1;

    typedef struct {
        logic [1:0] src;
        int         start;
        int         width;
    } pulseExp_t;

    logic      clk;
    logic      rst_n;
    int        cyc;
    int        checks;
    int        failures;
    int        c;
    int        s;
    pulseExp_t expQ[$];
    pulseExp_t curExp;
    logic      prevActive;
    logic      haveCur;
    int        riseCyc;

    zint_arb_if bus ();

    zint_arb #(
        .PULSE_CYC (PULSE_CYC),
        .GAP_CYC   (GAP_CYC),
        .CNT_W     (9)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter: number of rising edges seen so far.
    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic w5300N, input logic sl811Req);
        bus.w5300_int_n = w5300N;
        bus.sl811_intrq = sl811Req;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse monitor: pops the scoreboard on every INT rise and checks width on the fall.
    initial begin
        prevActive = 1'b0;
        haveCur    = 1'b0;
        riseCyc    = 0;
        forever begin
            @(negedge clk);
            if (bus.int_active === 1'b1 && !prevActive) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    curExp = expQ.pop_front();
                    checkOutput("pulse_src", {30'd0, bus.src}, {30'd0, curExp.src});
                    checkOutput("pulse_start", cyc, curExp.start);
                    riseCyc = cyc;
                    haveCur = 1'b1;
                end
            end
            if (bus.int_active === 1'b0 && prevActive && haveCur) begin
                checkOutput("pulse_width", cyc - riseCyc, curExp.width);
                haveCur = 1'b0;
            end
            prevActive = (bus.int_active === 1'b1);
        end
    end

    // Directed sequence.
    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        applyStimulus(1'b1, 1'b0);
        bus.ena_w5300_int = 1'b1;
        bus.ena_sl811_int = 1'b1;
        bus.ena_zxbus_int = 1'b1;
        bus.ack_stb       = 1'b0;
        bus.ack_mask      = 2'b00;

        stepCycles(3);
        checkOutput("rst_pending", {30'd0, bus.pending}, 32'd0);
        checkOutput("rst_src", {30'd0, bus.src}, 32'd0);
        checkOutput("rst_int_active", {31'd0, bus.int_active}, 32'd0);
        checkOutput("rst_internal_int", {31'd0, bus.internal_int}, 32'd0);
        rst_n = 1'b1;
        stepCycles(5);

        // Single W5300 request, acked during its pulse.
        c = cyc;
        applyStimulus(1'b0, 1'b0);
        expQ.push_back('{2'b01, c + 4, PULSE_CYC});
        stepCycles(2);
        checkOutput("t1_pending_before_e2", {30'd0, bus.pending}, 32'd0);
        stepCycles(1);
        checkOutput("t1_pending_e2", {30'd0, bus.pending}, 32'd1);
        checkOutput("t1_internal_int", {31'd0, bus.internal_int}, 32'd1);
        stepCycles(1);
        checkOutput("t1_int_active_e3", {31'd0, bus.int_active}, 32'd1);
        checkOutput("t1_src", {30'd0, bus.src}, 32'd1);
        stepCycles(10);
        bus.ack_stb  = 1'b1;
        bus.ack_mask = 2'b01;
        stepCycles(1);
        bus.ack_stb  = 1'b0;
        bus.ack_mask = 2'b00;
        checkOutput("t1_pending_after_ack", {30'd0, bus.pending}, 32'd0);
        checkOutput("t1_internal_int_after_ack", {31'd0, bus.internal_int}, 32'd0);
        checkOutput("t1_pulse_not_shortened", {31'd0, bus.int_active}, 32'd1);
        applyStimulus(1'b1, 1'b0);
        stepCycles(PERIOD + 20);
        checkOutput("t1_no_second_pulse", {31'd0, bus.int_active}, 32'd0);
        checkOutput("t1_src_held", {30'd0, bus.src}, 32'd1);

        // Simultaneous requests after reset, held without ack, then early abort.
        rst_n = 1'b0;
        stepCycles(1);
        rst_n = 1'b1;
        checkOutput("t2_rst_src", {30'd0, bus.src}, 32'd0);
        stepCycles(5);
        c = cyc;
        applyStimulus(1'b0, 1'b1);
        s = c + 4 + 2 * PERIOD;
        expQ.push_back('{2'b01, c + 4, PULSE_CYC});
        expQ.push_back('{2'b10, c + 4 + PERIOD, PULSE_CYC});
        expQ.push_back('{2'b01, s, 5});
        stepCycles(3);
        checkOutput("t2_pending_both", {30'd0, bus.pending}, 32'd3);
        stepCycles(s + 4 - cyc);
        bus.ena_zxbus_int = 1'b0;
        stepCycles(1);
        checkOutput("t4_abort_int_low", {31'd0, bus.int_active}, 32'd0);
        checkOutput("t4_abort_pending", {30'd0, bus.pending}, 32'd3);
        checkOutput("t4_abort_internal_int", {31'd0, bus.internal_int}, 32'd1);
        expQ.push_back('{2'b10, s + 262, PULSE_CYC});
        bus.ena_zxbus_int = 1'b1;
        stepCycles(256);
        checkOutput("t4_gap_still_low", {31'd0, bus.int_active}, 32'd0);
        stepCycles(1);
        checkOutput("t4_next_pulse", {31'd0, bus.int_active}, 32'd1);
        checkOutput("t4_next_src", {30'd0, bus.src}, 32'd2);
        stepCycles(2);
        bus.ack_stb  = 1'b1;
        bus.ack_mask = 2'b11;
        applyStimulus(1'b1, 1'b0);
        stepCycles(1);
        bus.ack_stb  = 1'b0;
        bus.ack_mask = 2'b00;
        checkOutput("t4_pending_acked", {30'd0, bus.pending}, 32'd0);
        checkOutput("t4_pulse_continues", {31'd0, bus.int_active}, 32'd1);
        stepCycles(PERIOD + 20);
        checkOutput("t4_idle", {31'd0, bus.int_active}, 32'd0);

        // Set/ack collision on the SL811 bit, then source disable.
        c = cyc;
        applyStimulus(1'b1, 1'b1);
        stepCycles(2);
        bus.ack_stb  = 1'b1;
        bus.ack_mask = 2'b10;
        stepCycles(1);
        bus.ack_stb  = 1'b0;
        bus.ack_mask = 2'b00;
        checkOutput("t5_set_beats_ack", {30'd0, bus.pending}, 32'd2);
        expQ.push_back('{2'b10, c + 4, PULSE_CYC});
        bus.ena_sl811_int = 1'b0;
        stepCycles(1);
        checkOutput("t5_disable_clears", {30'd0, bus.pending}, 32'd0);
        checkOutput("t5_internal_int", {31'd0, bus.internal_int}, 32'd0);
        stepCycles(PERIOD + 10);
        applyStimulus(1'b1, 1'b0);
        bus.ena_sl811_int = 1'b1;
        stepCycles(5);

        // Reset in the middle of a pulse with the W5300 request held low.
        c = cyc;
        applyStimulus(1'b0, 1'b0);
        s = c + 4;
        expQ.push_back('{2'b01, s, 11});
        stepCycles(3);
        checkOutput("t6_pending_set", {30'd0, bus.pending}, 32'd1);
        stepCycles(11);
        rst_n = 1'b0;
        stepCycles(1);
        rst_n = 1'b1;
        checkOutput("t6_rst_int_active", {31'd0, bus.int_active}, 32'd0);
        checkOutput("t6_rst_pending", {30'd0, bus.pending}, 32'd0);
        checkOutput("t6_rst_src", {30'd0, bus.src}, 32'd0);
        stepCycles(PERIOD + 20);
        checkOutput("t6_held_not_latched", {30'd0, bus.pending}, 32'd0);
        checkOutput("t6_no_pulse", {31'd0, bus.int_active}, 32'd0);
        applyStimulus(1'b1, 1'b0);
        stepCycles(4);
        c = cyc;
        applyStimulus(1'b0, 1'b0);
        expQ.push_back('{2'b01, c + 4, PULSE_CYC});
        stepCycles(3);
        checkOutput("t6_new_edge_pending", {30'd0, bus.pending}, 32'd1);
        stepCycles(1);
        checkOutput("t6_new_pulse_src", {30'd0, bus.src}, 32'd1);
        stepCycles(2);
        bus.ack_stb  = 1'b1;
        bus.ack_mask = 2'b01;
        applyStimulus(1'b1, 1'b0);
        stepCycles(1);
        bus.ack_stb  = 1'b0;
        bus.ack_mask = 2'b00;
        stepCycles(PULSE_CYC + 5);
        checkOutput("end_int_active", {31'd0, bus.int_active}, 32'd0);
        checkOutput("end_scoreboard_empty", expQ.size(), 32'd0);
        checkOutput("end_no_open_pulse", {31'd0, haveCur}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
